// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Covers the FSM state encoding, PC defaults and the redirect priority rule.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, KILL, FULL} fetch_state_t;

  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // The branch is the older instruction, so it beats a jump decoded in the same cycle.
  // Fetch addresses are word aligned, so the low two bits are dropped.
  function automatic logic [31:0] redirect_target(input logic        branch_taken,
                                                  input logic [31:0] branch_target,
                                                  input logic [31:0] jump_target);
    logic [31:0] t;
    t = branch_taken ? branch_target : jump_target;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/ack bus used between the fetch sequencer and imem.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect target select, alignment masking and sequential increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        inc_load,
  input  logic [31:0] inc_base,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] inc_next,
  output logic [31:0] pc
);

  assign redirect = branch_taken | jump;
  assign target   = redirect_target(branch_taken, branch_target, jump_target);
  assign inc_next = inc_base + PC_STEP;

  // A redirect always wins over the sequential update from a completed fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (inc_load) begin
      pc <= inc_next;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect kill handling
// and a single-entry IF/ID output register drained by decode under stall.
//
//  state | meaning
//  IDLE  | out of reset, no request yet
//  REQ   | request live at imem_addr, waiting for ack
//  KILL  | request live but redirected; its data will be dropped
//  FULL  | IF/ID register holds an instruction, no request
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  input  logic          stall,
  fetch_if.master       imem,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_pc4
);

  fetch_state_t state;
  logic         req_q;
  logic [31:0]  addr_q;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  addr_next;
  logic [31:0]  pc;
  logic         ack;

  assign ack            = imem.imem_ack;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  fetch_pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .inc_load      ((state == REQ) && ack),
    .inc_base      (addr_q),
    .redirect      (redirect),
    .target        (target),
    .inc_next      (addr_next),
    .pc            (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_pc4   <= '0;
    end else begin
      if (redirect) if_valid <= 1'b0;
      case (state)
        IDLE: begin
          state  <= REQ;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        REQ: begin
          if (ack && !redirect) begin
            if_instr <= imem.imem_rdata;
            if_pc    <= addr_q;
            if_pc4   <= addr_next;
            if_valid <= 1'b1;
            req_q    <= 1'b0;
            state    <= FULL;
          end else if (ack) begin
            addr_q <= target;
          end else if (redirect) begin
            // Address must stay put until the killed request is acknowledged.
            state <= KILL;
          end
        end
        KILL: begin
          if (ack) begin
            addr_q <= redirect ? target : pc;
            state  <= REQ;
          end
        end
        FULL: begin
          if (redirect) begin
            if_valid <= 1'b0;
            addr_q   <= target;
            req_q    <= 1'b1;
            state    <= REQ;
          end else if (!stall) begin
            if_valid <= 1'b0;
            addr_q   <= pc;
            req_q    <= 1'b1;
            state    <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances, one at the default reset PC and
// one starting at the top of the address space to exercise PC wrap-around.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, reset1 = 1'b1;
  logic        br = 1'b0, jmp = 1'b0, stall = 1'b0;
  logic [31:0] bt = '0, jt = '0;
  logic        jmp1 = 1'b0;
  logic [31:0] jt1 = '0;
  logic        tie0 = 1'b1, ack0 = 1'b0;
  logic        v0, v1;
  logic [31:0] i0, p0, p40, i1, p1, p41;
  int          n_cmp = 0, n_err = 0;

  fetch_if bus0 ();
  fetch_if bus1 ();

  assign bus0.imem_ack   = tie0 ? bus0.imem_req : ack0;
  assign bus0.imem_rdata = bus0.imem_addr ^ MAGIC;
  assign bus1.imem_ack   = bus1.imem_req;
  assign bus1.imem_rdata = bus1.imem_addr ^ MAGIC;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .branch_taken(br), .branch_target(bt),
    .jump(jmp), .jump_target(jt), .stall(stall), .imem(bus0.master),
    .if_valid(v0), .if_instr(i0), .if_pc(p0), .if_pc4(p40));

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset1), .branch_taken(1'b0), .branch_target(32'h0),
    .jump(jmp1), .jump_target(jt1), .stall(1'b0), .imem(bus1.master),
    .if_valid(v1), .if_instr(i1), .if_pc(p1), .if_pc4(p41));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string name, input logic req, input logic [31:0] addr);
    n_cmp++;
    if (bus0.imem_req !== req || bus0.imem_addr !== addr) begin
      n_err++;
      $display("FAIL %s: req=%b addr=%h, expected req=%b addr=%h", name, bus0.imem_req, bus0.imem_addr, req, addr);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] pc, input logic [31:0] pc4);
    n_cmp++;
    if (v0 !== v || (v && (p0 !== pc || p40 !== pc4 || i0 !== (pc ^ MAGIC)))) begin
      n_err++;
      $display("FAIL %s: valid=%b pc=%h pc4=%h instr=%h, expected valid=%b pc=%h pc4=%h", name, v0, p0, p40, i0, v, pc, pc4);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus0.imem_req !== 1'b0 || bus0.imem_addr !== 32'h0 || v0 !== 1'b0 ||
        i0 !== 32'h0 || p0 !== 32'h0 || p40 !== 32'h0 || dut.state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h pc=%h pc4=%h st=%0d, expected all zero IDLE",
               bus0.imem_req, bus0.imem_addr, v0, i0, p0, p40, dut.state);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_req("seq_req", 1'b1, 32'(k * 4));
      chk_out("seq_idle_out", 1'b0, 32'h0, 32'h0);
      tick(); chk_out("seq_out", 1'b1, 32'(k * 4), 32'(k * 4 + 4));
      chk_req("seq_noreq", 1'b0, 32'(k * 4));
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("stall_hold", 1'b1, 32'h8, 32'hC);
      chk_req("stall_noreq", 1'b0, 32'h8);
    end
    stall = 1'b0;
    tick(); chk_req("stall_release", 1'b1, 32'hC);
    tick(); chk_out("stall_next", 1'b1, 32'hC, 32'h10);
  endtask

  task automatic test_kill();
    tie0 = 1'b0; ack0 = 1'b0;
    tick(); chk_req("kill_req", 1'b1, 32'h10);
    jmp = 1'b1; jt = 32'h100;
    tick(); chk_req("kill_hold1", 1'b1, 32'h10);
    chk_out("kill_noval1", 1'b0, 32'h0, 32'h0);
    jmp = 1'b0;
    tick(); chk_req("kill_hold2", 1'b1, 32'h10);
    ack0 = 1'b1;
    tick(); chk_req("kill_newaddr", 1'b1, 32'h100);
    chk_out("kill_dropped", 1'b0, 32'h0, 32'h0);
    ack0 = 1'b0; tie0 = 1'b1;
    tick(); chk_out("kill_target_out", 1'b1, 32'h100, 32'h104);
  endtask

  task automatic test_priority();
    br = 1'b1; bt = 32'h40; jmp = 1'b1; jt = 32'h80;
    tick(); chk_req("prio_branch", 1'b1, 32'h40);
    chk_out("prio_clear", 1'b0, 32'h0, 32'h0);
    br = 1'b0; jmp = 1'b0;
    tick(); chk_out("prio_out", 1'b1, 32'h40, 32'h44);
    tick(); chk_req("prio_seq", 1'b1, 32'h44);
    jmp = 1'b1; jt = 32'h200;
    tick(); chk_req("req_ack_redirect", 1'b1, 32'h200);
    chk_out("req_ack_dropped", 1'b0, 32'h0, 32'h0);
    jmp = 1'b0;
    tick(); chk_out("req_ack_out", 1'b1, 32'h200, 32'h204);
  endtask

  task automatic test_reset_in_kill();
    tie0 = 1'b0; ack0 = 1'b0;
    tick(); chk_req("rk_req", 1'b1, 32'h204);
    jmp = 1'b1; jt = 32'h300;
    tick(); chk_req("rk_kill", 1'b1, 32'h204);
    jmp = 1'b0; ack0 = 1'b1; reset = 1'b1;
    tick();
    n_cmp++;
    if (bus0.imem_req !== 1'b0 || bus0.imem_addr !== 32'h0 || v0 !== 1'b0 ||
        i0 !== 32'h0 || p0 !== 32'h0 || p40 !== 32'h0 || dut.state !== IDLE) begin
      n_err++;
      $display("FAIL rk_reset: req=%b addr=%h v=%b instr=%h pc=%h pc4=%h st=%0d, expected all zero IDLE",
               bus0.imem_req, bus0.imem_addr, v0, i0, p0, p40, dut.state);
    end
    reset = 1'b0; ack0 = 1'b0; tie0 = 1'b1;
    tick(); chk_req("rk_refetch", 1'b1, 32'h0);
  endtask

  task automatic test_wrap();
    reset1 = 1'b0;
    tick();
    n_cmp++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_first: req=%b addr=%h, expected 1 fffffffc", bus1.imem_req, bus1.imem_addr);
    end
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || p1 !== 32'hFFFF_FFFC || p41 !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc4: v=%b pc=%h pc4=%h, expected 1 fffffffc 00000000", v1, p1, p41);
    end
    tick();
    n_cmp++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_second: req=%b addr=%h, expected 1 00000000", bus1.imem_req, bus1.imem_addr);
    end
    jmp1 = 1'b1; jt1 = 32'h103;
    tick();
    n_cmp++;
    if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL wrap_align: req=%b addr=%h, expected 1 00000100", bus1.imem_req, bus1.imem_addr);
    end
    jmp1 = 1'b0;
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || p1 !== 32'h100 || p41 !== 32'h104 || i1 !== (32'h100 ^ MAGIC)) begin
      n_err++;
      $display("FAIL wrap_align_out: v=%b pc=%h pc4=%h instr=%h, expected 1 00000100 00000104", v1, p1, p41, i1);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_kill();
    test_priority();
    test_reset_in_kill();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences instruction fetch for the 32-bit MIPS core. It owns the program counter and issues one request at a time to instruction memory over a req/ack handshake. It applies branch and jump redirects and discards any in-flight fetch they kill. It presents each fetched instruction in a one-entry IF/ID output register that decode drains under a stall signal.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
branch_taken  in  1  branch resolved taken this cycle.
branch_target  in  32  branch destination.
jump  in  1  jump decoded this cycle.
jump_target  in  32  jump destination.
stall  in  1  decode cannot accept if_instr this cycle.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; stable while imem_req=1.
imem_ack  in  1  instruction memory returns data this cycle; may assert in the same cycle as imem_req.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
if_valid  out  1  if_instr holds a live instruction.
if_instr  out  32  fetched instruction.
if_pc  out  32  address of if_instr.
if_pc4  out  32  if_pc + PC_STEP.

Behaviour:
- Reset (synchronous, highest priority):
  - Outputs: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, if_pc4=0.
  - Instruction memory shares this reset and drops its pending request.
- Redirect:
  - redirect = branch_taken | jump.
  - Target is branch_target when branch_taken=1, otherwise jump_target; branch wins because it is the older instruction.
  - Target bits [1:0] are forced to 00.
  - On every redirect, if_valid clears on the same edge.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- At most one request is outstanding. A request is issued only when the output register is empty or being drained in the same cycle.
- States:
  - IDLE: imem_req=0. Moves to REQ on the next edge, loading imem_addr=pc. A redirect here updates pc only.
  - REQ: imem_req=1 and imem_addr held.
    - ack without redirect: if_instr<=imem_rdata, if_pc<=imem_addr, if_pc4<=imem_addr+4, if_valid<=1, pc<=imem_addr+4, go to FULL.
    - ack with redirect: discard the data, pc<=target, imem_addr<=target, stay in REQ.
    - redirect without ack: pc<=target, go to KILL. imem_addr keeps the old address, because the handshake forbids address change mid-request.
  - KILL: imem_req=1 with the stale address.
    - Further redirects overwrite pc; the newest wins.
    - On ack, the data is discarded, imem_addr<=pc, go to REQ.
  - FULL: imem_req=0, output held.
    - stall=1 and no redirect: hold everything.
    - stall=0: if_valid<=0, imem_addr<=pc, go to REQ.
    - redirect: if_valid<=0, pc<=target, imem_addr<=target, go to REQ; stall is ignored.
- Latency and throughput:
  - With ack in the same cycle as req, if_valid rises 1 cycle after the request cycle.
  - Steady-state throughput with no stalls is one instruction per 2 cycles.
- imem_ack while imem_req=0 is ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, REQ, KILL, FULL}
  - PC_STEP constant
  - default RESET_PC
  - redirect priority encoding
- One sub-module, fetch_pc_reg: the pc register with target select, [1:0] masking and the +4 adder.
- The FSM and the IF/ID output register stay in fetch_sequencer.

Test Plan:
1. Reset, then ack tied to req, stall=0 -> imem_addr sequence 0,4,8; if_valid pulses every 2nd cycle; if_pc=0,4,8; if_pc4=4,8,12.
2. Hold stall=1 with if_valid=1 for 5 cycles -> if_instr/if_pc unchanged, imem_req=0; after stall falls, the next request addr = if_pc+4.
3. Ack delayed 3 cycles; jump to 32'h0000_0100 asserted in the 1st wait cycle -> imem_addr stays old until ack; that data is not shown (if_valid stays 0); next request addr=0x100.
4. branch_taken (target 0x40) and jump (target 0x80) in the same cycle -> next fetch addr=0x40.
5. Start at RESET_PC=32'hFFFF_FFFC -> second fetch addr=0x0000_0000, if_pc4=0; redirect target 0x103 -> fetch addr 0x100.
6. reset asserted in KILL with ack pending -> next cycle all outputs at reset values, state IDLE; a following fetch addr=RESET_PC.
